pipeline_fwd_core: RTL and testbench

PIPELINE_FWD_CORE -- requirements
Module: pipeline_fwd_core

---
 rtl/pipeline_fwd_core_if.sv | 34 +++
 rtl/pipeline_fwd_core.sv | 220 ++++++++++++++++++++++
 tb/tb_pipeline_fwd_core.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_fwd_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_fwd_core_if : fetch, writeback, status and debug bus of the core   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface pipeline_fwd_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
);
  logic              inst_valid;
  logic [15:0]       inst;
  logic              inst_ready;
  logic [PC_W-1:0]   fetch_pc;
  logic              redirect;
  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mult_busy;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output inst_valid, inst, dbg_addr,
    input  inst_ready, fetch_pc, redirect, wb_valid, wb_rd, wb_data,
           mult_busy, dbg_data
  );

  modport slave (
    input  inst_valid, inst, dbg_addr,
    output inst_ready, fetch_pc, redirect, wb_valid, wb_rd, wb_data,
           mult_busy, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_fwd_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_fwd_core : 3-stage (D/E/M) core with full forwarding, iterative    |
// | multiplier and HI/LO. Revision 1.0                                          |
// +----------------------------------------------------------------------------+
module pipeline_fwd_core #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 16,
  parameter int PC_W     = 12,
  parameter int MULT_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipeline_fwd_core_if.slave bus
);

  localparam logic [3:0] c_op_add  = 4'h0;
  localparam logic [3:0] c_op_sub  = 4'h1;
  localparam logic [3:0] c_op_slti = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_xor  = 4'h5;
  localparam logic [3:0] c_op_andi = 4'h6;
  localparam logic [3:0] c_op_ori  = 4'h7;
  localparam logic [3:0] c_op_xori = 4'h8;
  localparam logic [3:0] c_op_addi = 4'h9;
  localparam logic [3:0] c_op_subi = 4'hA;
  localparam logic [3:0] c_op_jmp  = 4'hB;
  localparam logic [3:0] c_op_brz  = 4'hC;
  localparam logic [3:0] c_op_mfl  = 4'hD;
  localparam logic [3:0] c_op_mfh  = 4'hE;
  localparam logic [3:0] c_op_mult = 4'hF;
  localparam int         c_cnt_w   = $clog2(MULT_LAT + 1);

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mult_state_t;

  logic [DATA_W-1:0]   r_rf [NREG];
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [PC_W-1:0]     r_fetch_pc;
  logic                r_d_valid;
  logic [15:0]         r_d_inst;
  logic [PC_W-1:0]     r_d_pc;
  logic                r_e_valid, r_e_wb;
  logic [3:0]          r_e_op, r_e_rd, r_e_imm;
  logic [DATA_W-1:0]   r_e_rs_val, r_e_rt_val;
  logic                r_wb_valid;
  logic [3:0]          r_wb_rd;
  logic [DATA_W-1:0]   r_wb_data;
  logic [DATA_W-1:0]   r_mult_a, r_mult_b;
  logic [c_cnt_w-1:0]  r_mult_cnt;
  mult_state_t         r_mstate, w_mstate_next;

  logic [3:0]          w_d_op, w_d_rd, w_d_rs, w_d_rt;
  logic                w_d_wb, w_d_mul_use;
  logic [DATA_W-1:0]   w_rs_val, w_rt_val;
  logic                w_redirect, w_stall, w_inst_ready, w_xfer;
  logic [PC_W-1:0]     w_target;
  logic [DATA_W-1:0]   w_e_imm, w_e_result;
  logic                w_mult_start, w_mult_busy, w_hilo_load;
  logic [2*DATA_W-1:0] w_product;

  function automatic logic [DATA_W-1:0] f_rf_rd(input logic [3:0] idx);
    if (int'(idx) < NREG) return r_rf[idx];
    return '0;
  endfunction

  // Youngest producer wins: E result, then the registered writeback, then the RF.
  function automatic logic [DATA_W-1:0] f_src(input logic [3:0] idx);
    if (int'(idx) >= NREG)                          return '0;
    if (r_e_valid && r_e_wb && (r_e_rd == idx))     return w_e_result;
    if (r_wb_valid && (r_wb_rd == idx))             return r_wb_data;
    return r_rf[idx];
  endfunction

  assign w_d_op      = r_d_inst[15:12];
  assign w_d_rd      = r_d_inst[11:8];
  assign w_d_rs      = r_d_inst[7:4];
  assign w_d_rt      = r_d_inst[3:0];
  assign w_d_wb      = (w_d_op <= c_op_subi) || (w_d_op == c_op_mfl) || (w_d_op == c_op_mfh);
  assign w_d_mul_use = (w_d_op == c_op_mfl) || (w_d_op == c_op_mfh) || (w_d_op == c_op_mult);
  assign w_rs_val    = f_src(w_d_rs);
  assign w_rt_val    = f_src(w_d_rt);

  assign w_redirect = r_d_valid && ((w_d_op == c_op_jmp) ||
                                    ((w_d_op == c_op_brz) && (w_rs_val == '0)));
  assign w_target   = (w_d_op == c_op_jmp) ? PC_W'(r_d_inst[11:0])
                    : r_d_pc + PC_W'(1) + PC_W'($signed({w_d_rd, w_d_rt}));

  assign w_mult_busy  = (r_mstate == MS_BUSY);
  assign w_mult_start = r_e_valid && (r_e_op == c_op_mult);
  assign w_stall      = r_d_valid && w_d_mul_use && (w_mult_busy || w_mult_start);
  assign w_inst_ready = !reset && !w_stall && !w_redirect;
  assign w_xfer       = bus.inst_valid && w_inst_ready;

  assign w_e_imm = DATA_W'(r_e_imm);

  always_comb begin
    w_e_result = '0;
    case (r_e_op)
      c_op_add:  w_e_result = r_e_rs_val + r_e_rt_val;
      c_op_sub:  w_e_result = r_e_rs_val - r_e_rt_val;
      c_op_slti: w_e_result = DATA_W'(r_e_rt_val > w_e_imm);
      c_op_and:  w_e_result = r_e_rt_val & r_e_rs_val;
      c_op_or:   w_e_result = r_e_rt_val | r_e_rs_val;
      c_op_xor:  w_e_result = r_e_rt_val ^ r_e_rs_val;
      c_op_andi: w_e_result = r_e_rt_val & w_e_imm;
      c_op_ori:  w_e_result = r_e_rt_val | w_e_imm;
      c_op_xori: w_e_result = r_e_rt_val ^ w_e_imm;
      c_op_addi: w_e_result = r_e_rt_val + w_e_imm;
      c_op_subi: w_e_result = r_e_rt_val - w_e_imm;
      c_op_mfl:  w_e_result = r_lo;
      c_op_mfh:  w_e_result = r_hi;
      default:   w_e_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= '0;
      r_d_valid  <= 1'b0;
      r_d_inst   <= '0;
      r_d_pc     <= '0;
      r_e_valid  <= 1'b0;
      r_e_wb     <= 1'b0;
      r_e_op     <= '0;
      r_e_rd     <= '0;
      r_e_imm    <= '0;
      r_e_rs_val <= '0;
      r_e_rt_val <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      if (w_redirect)  r_fetch_pc <= w_target;
      else if (w_xfer) r_fetch_pc <= r_fetch_pc + PC_W'(1);

      if (w_redirect) begin
        r_d_valid <= 1'b0;
      end else if (!w_stall) begin
        r_d_valid <= w_xfer;
        r_d_inst  <= bus.inst;
        r_d_pc    <= r_fetch_pc;
      end

      r_e_valid  <= r_d_valid && !w_stall;
      r_e_wb     <= w_d_wb;
      r_e_op     <= w_d_op;
      r_e_rd     <= w_d_rd;
      r_e_imm    <= w_d_rs;
      r_e_rs_val <= w_rs_val;
      r_e_rt_val <= w_rt_val;

      r_wb_valid <= r_e_valid && r_e_wb;
      if (r_e_valid && r_e_wb) begin
        r_wb_rd   <= r_e_rd;
        r_wb_data <= w_e_result;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_wb_valid && (int'(r_wb_rd) < NREG)) begin
      r_rf[r_wb_rd] <= r_wb_data;
    end
  end

  assign w_product = {{DATA_W{1'b0}}, r_mult_a} * {{DATA_W{1'b0}}, r_mult_b};

  always_comb begin
    w_mstate_next = r_mstate;
    w_hilo_load   = 1'b0;
    case (r_mstate)
      MS_IDLE: if (w_mult_start) w_mstate_next = MS_BUSY;
      MS_BUSY: begin
        if (r_mult_cnt == c_cnt_w'(1)) begin
          w_mstate_next = MS_IDLE;
          w_hilo_load   = 1'b1;
        end
      end
      default: w_mstate_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstate   <= MS_IDLE;
      r_mult_cnt <= '0;
      r_mult_a   <= '0;
      r_mult_b   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_mstate <= w_mstate_next;
      if (w_mult_start) begin
        r_mult_a   <= r_e_rs_val;
        r_mult_b   <= r_e_rt_val;
        r_mult_cnt <= c_cnt_w'(MULT_LAT);
      end else if (w_mult_busy) begin
        r_mult_cnt <= r_mult_cnt - c_cnt_w'(1);
      end
      if (w_hilo_load) {r_hi, r_lo} <= w_product;
    end
  end

  assign bus.inst_ready = w_inst_ready;
  assign bus.fetch_pc   = r_fetch_pc;
  assign bus.redirect   = w_redirect;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.mult_busy  = w_mult_busy;
  assign bus.dbg_data   = f_rf_rd(bus.dbg_addr);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fwd_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_fwd_core : scoreboard bench with an instruction-level model     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_pipeline_fwd_core;
  localparam int DATA_W   = 16;
  localparam int NREG     = 16;
  localparam int PC_W     = 12;
  localparam int MULT_LAT = 4;

  typedef struct packed {
    logic [3:0]        rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pipeline_fwd_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  pipeline_fwd_core #(
    .DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .MULT_LAT(MULT_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                busy_cycles = 0;
  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] m_rf [16];
  logic [DATA_W-1:0] m_hi, m_lo;
  logic [PC_W-1:0]   m_pc;

  // Architectural model: applied in program order at the moment of acceptance.
  function automatic void model_apply(input logic [15:0] w);
    logic [3:0]          op, rd, rs, rt;
    logic [DATA_W-1:0]   a, b, imm, r;
    logic [2*DATA_W-1:0] p;
    logic [PC_W-1:0]     pc0;
    logic                wb;
    op = w[15:12]; rd = w[11:8]; rs = w[7:4]; rt = w[3:0];
    a = m_rf[rs]; b = m_rf[rt]; imm = {12'h000, rs};
    pc0 = m_pc; m_pc = m_pc + 12'd1; wb = 1'b1; r = '0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = (b > imm) ? 16'd1 : 16'd0;
      4'h3: r = b & a;
      4'h4: r = b | a;
      4'h5: r = b ^ a;
      4'h6: r = b & imm;
      4'h7: r = b | imm;
      4'h8: r = b ^ imm;
      4'h9: r = b + imm;
      4'hA: r = b - imm;
      4'hB: begin wb = 1'b0; m_pc = w[11:0]; end
      4'hC: begin
        wb = 1'b0;
        if (a == '0) m_pc = pc0 + 12'd1 + {{4{w[11]}}, w[11:8], w[3:0]};
      end
      4'hD: r = m_lo;
      4'hE: r = m_hi;
      default: begin
        wb = 1'b0;
        p = {16'h0000, a} * {16'h0000, b};
        m_hi = p[31:16];
        m_lo = p[15:0];
      end
    endcase
    if (wb) begin
      m_rf[rd] = r;
      exp_q.push_back({rd, r});
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.mult_busy) busy_cycles++;
      if (!reset && bus.wb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", bus.wb_rd, bus.wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.wb_rd !== mon_e.rd || bus.wb_data !== mon_e.data) begin
            errors++;
            $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                     bus.wb_rd, bus.wb_data, mon_e.rd, mon_e.data);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst = 16'h0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [15:0] w, output int stalls);
    stalls = 0;
    bus.inst_valid = 1'b1;
    bus.inst = w;
    #1;
    while (!bus.inst_ready && stalls < 64) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!bus.inst_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: inst=%h inst_ready=0 after %0d cycles, required 1", w, stalls);
    end else begin
      model_apply(w);
    end
    @(negedge clk);
    bus.inst_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst = 16'h9150;
    bus.dbg_addr = 4'd1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.inst_ready, bus.redirect, bus.wb_valid, bus.mult_busy, bus.wb_rd, bus.wb_data,
         bus.fetch_pc, bus.dbg_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b redir=%b wbv=%b busy=%b rd=%h data=%h pc=%h dbg=%h, required all 0",
               bus.inst_ready, bus.redirect, bus.wb_valid, bus.mult_busy, bus.wb_rd, bus.wb_data,
               bus.fetch_pc, bus.dbg_data);
    end
    do_reset();
    #1;
    checks++;
    if (bus.inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.inst_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_addi();
    int s;
    do_reset();
    issue(16'h9150, s);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL addi_wb_edge1: got %b, required 0", bus.wb_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL addi_wb_edge2: got %b, required 0", bus.wb_valid);
    end
    @(negedge clk);
    bus.dbg_addr = 4'd1;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd1 || bus.wb_data !== 16'd5) begin
      errors++;
      $display("FAIL addi_wb: got v=%b rd=%0d data=%h, required v=1 rd=1 data=0005",
               bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    checks++;
    if (bus.dbg_data !== 16'd0) begin
      errors++; $display("FAIL dbg_before_write: got %h, required 0000", bus.dbg_data);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'd5) begin
      errors++; $display("FAIL dbg_after_write: got %h, required 0005", bus.dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2;
    do_reset();
    issue(16'h9150, s0);
    issue(16'h0211, s1);
    issue(16'h0321, s2);
    checks++;
    if (s0 + s1 + s2 != 0) begin
      errors++; $display("FAIL b2b_ready: got %0d stall cycles, required 0", s0 + s1 + s2);
    end
    checks++;
    if (bus.fetch_pc !== 12'd3) begin
      errors++; $display("FAIL b2b_pc: got %h, required 003", bus.fetch_pc);
    end
    drain(4);
    bus.dbg_addr = 4'd2; #1;
    checks++;
    if (bus.dbg_data !== 16'd10) begin
      errors++; $display("FAIL b2b_r2: got %h, required 000a", bus.dbg_data);
    end
    bus.dbg_addr = 4'd3; #1;
    checks++;
    if (bus.dbg_data !== 16'd15) begin
      errors++; $display("FAIL b2b_r3: got %h, required 000f", bus.dbg_data);
    end
    @(negedge clk);
  endtask

  // MFL is refused once while MULT sits in E, then for the MULT_LAT busy cycles.
  task automatic test_mult_stall();
    int s0, s1, s2, b0;
    b0 = busy_cycles;
    issue(16'hF012, s0);
    issue(16'hD400, s1);
    issue(16'hE500, s2);
    checks++;
    if (s0 + s1 + s2 != MULT_LAT + 1) begin
      errors++; $display("FAIL mult_ready_low: got %0d cycles, required %0d", s0 + s1 + s2, MULT_LAT + 1);
    end
    drain(8);
    checks++;
    if (busy_cycles - b0 != MULT_LAT) begin
      errors++; $display("FAIL mult_busy_len: got %0d cycles, required %0d", busy_cycles - b0, MULT_LAT);
    end
    bus.dbg_addr = 4'd4; #1;
    checks++;
    if (bus.dbg_data !== 16'd50) begin
      errors++; $display("FAIL mult_r4: got %h, required 0032", bus.dbg_data);
    end
    bus.dbg_addr = 4'd5; #1;
    checks++;
    if (bus.dbg_data !== 16'd0) begin
      errors++; $display("FAIL mult_r5: got %h, required 0000", bus.dbg_data);
    end
    @(negedge clk);
  endtask

  task automatic test_jmp();
    int s;
    issue(16'hB020, s);
    checks++;
    if (bus.redirect !== 1'b1 || bus.inst_ready !== 1'b0) begin
      errors++; $display("FAIL jmp_redirect: got redir=%b rdy=%b, required redir=1 rdy=0", bus.redirect, bus.inst_ready);
    end
    bus.inst_valid = 1'b1;
    bus.inst = 16'h9170;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    checks++;
    if (bus.redirect !== 1'b0 || bus.fetch_pc !== 12'h020) begin
      errors++; $display("FAIL jmp_target: got redir=%b pc=%h, required redir=0 pc=020", bus.redirect, bus.fetch_pc);
    end
    drain(4);
    bus.dbg_addr = 4'd1; #1;
    checks++;
    if (bus.dbg_data !== 16'd5) begin
      errors++; $display("FAIL jmp_r1: got %h, required 0005", bus.dbg_data);
    end
    @(negedge clk);
  endtask

  task automatic test_brz_taken();
    int s;
    do_reset();
    repeat (3) issue(16'h9110, s);
    checks++;
    if (bus.fetch_pc !== 12'd3) begin
      errors++; $display("FAIL brz_t_pc_before: got %h, required 003", bus.fetch_pc);
    end
    issue(16'hC002, s);
    checks++;
    if (bus.redirect !== 1'b1) begin
      errors++; $display("FAIL brz_t_redirect: got %b, required 1", bus.redirect);
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_pc !== 12'd6 || bus.redirect !== 1'b0) begin
      errors++; $display("FAIL brz_t_target: got pc=%h redir=%b, required pc=006 redir=0", bus.fetch_pc, bus.redirect);
    end
    drain(3);
  endtask

  task automatic test_brz_not_taken();
    int s;
    do_reset();
    issue(16'h9110, s);
    issue(16'h9110, s);
    issue(16'h9070, s);
    issue(16'hC002, s);
    checks++;
    if (bus.redirect !== 1'b0 || bus.fetch_pc !== 12'd4 || bus.inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL brz_nt: got redir=%b pc=%h rdy=%b, required redir=0 pc=004 rdy=1",
               bus.redirect, bus.fetch_pc, bus.inst_ready);
    end
    drain(4);
  endtask

  task automatic test_random_ops();
    int s;
    logic [3:0] op;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd11) op = op + 4'd2;
      issue({op, 12'($urandom)}, s);
    end
    drain(12);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = i[3:0]; #1;
      checks++;
      if (bus.dbg_data !== m_rf[i]) begin
        errors++; $display("FAIL rand_reg%0d: got %h, required %h", i, bus.dbg_data, m_rf[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mult();
    int s, n;
    do_reset();
    issue(16'h9150, s);
    issue(16'h9270, s);
    issue(16'hF012, s);
    issue(16'h9330, s);
    n = 0;
    while (!bus.mult_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.mult_busy) begin
      errors++; $display("FAIL rmm_busy_wait: got mult_busy=0 after %0d cycles, required 1", n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mult_busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL rmm_abort: got busy=%b wbv=%b, required 0 0", bus.mult_busy, bus.wb_valid);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = i[3:0]; #1;
      checks++;
      if (bus.dbg_data !== 16'd0) begin
        errors++; $display("FAIL rmm_reg%0d: got %h, required 0000", i, bus.dbg_data);
      end
    end
    @(negedge clk);
    do_reset();
    drain(4);
    issue(16'hD600, s);
    issue(16'hE700, s);
    drain(4);
  endtask

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst = 16'h0000;
    bus.dbg_addr = 4'd0;
    fork
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_mult_stall();
    test_jmp();
    test_brz_taken();
    test_brz_not_taken();
    test_random_ops();
    test_reset_mid_mult();
    drain(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
